// File: rtl/qracc_act_loader.sv
// Activation loader: packs narrow activation beats into full MAC vectors for seq_acc,
// double-buffered (fill slot + output slot) so filling overlaps delivery.
module qracc_act_loader #(
   parameter int inputBits     = 5,
   parameter int inputElements = 128,
   parameter int beatElements  = 8,
   parameter int countBits     = 16
) (
   input  logic                                           clk,
   input  logic                                           nrst,
   input  logic                                           clear_i,
   input  logic [beatElements-1:0][inputBits-1:0]         act_data_i,
   input  logic                                           act_valid_i,
   output logic                                           act_ready_o,
   output logic [inputElements-1:0][inputBits-1:0]        mac_data_o,
   output logic                                           mac_valid_o,
   input  logic                                           mac_ready_i,
   output logic [countBits-1:0]                           vec_count_o
);

   localparam int BEATS = inputElements / beatElements;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if ((inputElements % beatElements) != 0 || inputElements < beatElements) begin : g_bad_cfg
      $error("qracc_act_loader: inputElements must be a positive multiple of beatElements");
   end

   // Both streams: a transfer happens on a rising edge where valid && ready;
   // the sender holds data stable until then, ready may depend on the consumer side.

   logic [BEATS-1:0][beatElements-1:0][inputBits-1:0] fill_q;
   logic [inputElements-1:0][inputBits-1:0]           out_q;
   logic [BW-1:0]                                     beat_q;
   logic                                              fill_full_q;
   logic                                              out_valid_q;
   logic [countBits-1:0]                              count_q;

   logic beat_fire;
   logic vec_fire;
   logic move;
   logic last_beat;

   assign move        = fill_full_q && (!out_valid_q || mac_ready_i);
   assign act_ready_o = nrst && (!fill_full_q || move);
   assign beat_fire   = act_valid_i && act_ready_o;
   assign vec_fire    = out_valid_q && mac_ready_i;
   assign last_beat   = (beat_q == BW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (!nrst || clear_i) begin
         fill_q      <= '0;
         out_q       <= '0;
         beat_q      <= '0;
         fill_full_q <= 1'b0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         // The fill slot may be rewritten on the same edge it moves out:
         // the output register captures the pre-edge contents.
         if (beat_fire) begin
            fill_q[beat_q] <= act_data_i;
            beat_q         <= last_beat ? '0 : beat_q + BW'(1);
         end

         fill_full_q <= (fill_full_q && !move) || (beat_fire && last_beat);

         if (move) begin
            out_q       <= fill_q;
            out_valid_q <= 1'b1;
         end else if (vec_fire) begin
            out_valid_q <= 1'b0;
         end

         if (vec_fire) begin
            count_q <= count_q + countBits'(1);
         end
      end
   end

   assign mac_data_o  = out_q;
   assign mac_valid_o = out_valid_q;
   assign vec_count_o = count_q;

endmodule

// File: tb/tb_qracc_act_loader.sv
// Directed bench for qracc_act_loader at default parameters (16 beats of 8 x 5-bit elements).
module tb_qracc_act_loader;

   localparam int IB    = 5;
   localparam int IE    = 128;
   localparam int BE    = 8;
   localparam int CB    = 16;
   localparam int BEATS = IE / BE;
   localparam int W     = IE * IB;

   typedef logic [BE-1:0][IB-1:0] beat_t;
   typedef logic [IE-1:0][IB-1:0] vec_t;

   logic          clk = 1'b0;
   logic          nrst;
   logic          clear;
   beat_t         act_data;
   logic          act_valid;
   logic          act_ready;
   vec_t          mac_data;
   logic          mac_valid;
   logic          mac_ready;
   logic [CB-1:0] vec_count;

   int tests_run = 0;
   int fails     = 0;

   logic [W-1:0]  exp_q[$];
   vec_t          got_q[$];
   int            got_t[$];
   logic [CB-1:0] got_cnt[$];
   bit            ready_low;
   bit            early;
   bit            unstable;

   qracc_act_loader #(
      .inputBits(IB), .inputElements(IE), .beatElements(BE), .countBits(CB)
   ) dut (
      .clk(clk), .nrst(nrst), .clear_i(clear),
      .act_data_i(act_data), .act_valid_i(act_valid), .act_ready_o(act_ready),
      .mac_data_o(mac_data), .mac_valid_o(mac_valid), .mac_ready_i(mac_ready),
      .vec_count_o(vec_count)
   );

   always #5 clk = ~clk;

   // Element i of vector v; vector 0 is the (i mod 8) - 4 pattern.
   function automatic logic [IB-1:0] elem(input int v, input int i);
      if (v == 0) return IB'((i % 8) - 4);
      return IB'(v * 13 + i * 7 + i / 8);
   endfunction

   function automatic beat_t make_beat(input int v, input int k);
      beat_t b;
      for (int j = 0; j < BE; j++) b[j] = elem(v, k * BE + j);
      return b;
   endfunction

   function automatic vec_t make_vec(input int v);
      vec_t x;
      for (int i = 0; i < IE; i++) x[i] = elem(v, i);
      return x;
   endfunction

   // Driver: offers beats b0..n_beats-1 (vector vec_base + b/BEATS) and collects
   // delivered vectors until `target` arrive (target 0: run max_cyc cycles).
   task automatic stream(input int b0, input int n_beats, input int vec_base, input bit rnd,
                         input int target, input int max_cyc, output int sent);
      int   cyc = 0;
      bit   hold_ok = 0;
      vec_t hold;
      sent = b0;
      got_q.delete(); got_t.delete(); got_cnt.delete();
      ready_low = 0; early = 0; unstable = 0;
      while (cyc < max_cyc && !(target > 0 && got_q.size() >= target)) begin
         act_valid = (sent < n_beats) && (!rnd || ($urandom_range(0, 1) == 1));
         act_data  = make_beat(vec_base + sent / BEATS, sent % BEATS);
         @(negedge clk);
         if (!act_ready) ready_low = 1;
         if (mac_valid && sent < n_beats) early = 1;
         if (act_valid && act_ready) sent++;
         if (mac_valid && mac_ready) begin
            got_q.push_back(mac_data);
            got_t.push_back(cyc);
            got_cnt.push_back(vec_count);
         end
         if (mac_valid && !mac_ready) begin
            if (hold_ok && mac_data !== hold) unstable = 1;
            hold = mac_data; hold_ok = 1;
         end else hold_ok = 0;
         @(posedge clk); #1;
         cyc++;
      end
      act_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0; clear = 1'b0; act_valid = 1'b0; act_data = '0; mac_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (mac_valid !== 1'b0) begin fails++; $display("FAIL reset_mac_valid got %0b exp 0", mac_valid); end
      tests_run++; if (mac_data !== '0) begin fails++; $display("FAIL reset_mac_data got %h exp 0", mac_data); end
      tests_run++; if (vec_count !== '0) begin fails++; $display("FAIL reset_vec_count got %0d exp 0", vec_count); end
      tests_run++; if (act_ready !== 1'b0) begin fails++; $display("FAIL reset_act_ready got %0b exp 0", act_ready); end
      nrst = 1'b1;
      #1;
      tests_run++; if (act_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %0b exp 1", act_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int sent;
      mac_ready = 1'b1;
      stream(0, 16, 0, 0, 1, 100, sent);
      tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
      else begin
         exp_q.push_back(make_vec(0));
         tests_run++; if (got_q[0] !== exp_q.pop_front()) begin fails++; $display("FAIL single_data got %h exp %h", got_q[0], make_vec(0)); end
         tests_run++; if (got_t[0] != 17) begin fails++; $display("FAIL single_latency got %0d exp 17", got_t[0]); end
      end
      tests_run++; if (vec_count !== 16'd1) begin fails++; $display("FAIL single_vec_count got %0d exp 1", vec_count); end
      tests_run++; if (mac_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %0b exp 0", mac_valid); end
   endtask

   task automatic test_clear_mid_fill();
      int sent;
      mac_ready = 1'b1;
      stream(0, 16, 50, 0, 0, 7, sent);
      tests_run++; if (sent != 7) begin fails++; $display("FAIL clear_pre_beats got %0d exp 7", sent); end
      clear = 1'b1; act_valid = 1'b1; act_data = make_beat(51, 0);
      @(posedge clk); #1;
      clear = 1'b0; act_valid = 1'b0;
      tests_run++; if (vec_count !== '0) begin fails++; $display("FAIL clear_vec_count got %0d exp 0", vec_count); end
      tests_run++; if (act_ready !== 1'b1) begin fails++; $display("FAIL clear_act_ready got %0b exp 1", act_ready); end
      stream(0, 16, 60, 0, 1, 100, sent);
      tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL clear_fresh_count got %0d exp 1", got_q.size()); end
      else begin
         exp_q.push_back(make_vec(60));
         tests_run++; if (got_q[0] !== exp_q.pop_front()) begin fails++; $display("FAIL clear_fresh_data got %h exp %h", got_q[0], make_vec(60)); end
         tests_run++; if (got_cnt[0] !== '0) begin fails++; $display("FAIL clear_count_before got %0d exp 0", got_cnt[0]); end
         tests_run++; if (got_t[0] != 17) begin fails++; $display("FAIL clear_fresh_latency got %0d exp 17", got_t[0]); end
      end
   endtask

   task automatic test_back_to_back();
      int sent;
      bit gap_bad = 0;
      do_clear();
      mac_ready = 1'b1;
      stream(0, 160, 30, 0, 10, 400, sent);
      tests_run++; if (got_q.size() != 10) begin fails++; $display("FAIL b2b_count got %0d exp 10", got_q.size()); end
      else begin
         for (int v = 0; v < 10; v++) exp_q.push_back(make_vec(30 + v));
         for (int v = 0; v < 10; v++) begin
            tests_run++; if (got_q[v] !== exp_q.pop_front()) begin fails++; $display("FAIL b2b_data v%0d got %h exp %h", v, got_q[v], make_vec(30 + v)); end
            if (v > 0 && got_t[v] - got_t[v-1] != 16) gap_bad = 1;
         end
         tests_run++; if (got_t[0] != 17) begin fails++; $display("FAIL b2b_first got %0d exp 17", got_t[0]); end
         tests_run++; if (gap_bad) begin fails++; $display("FAIL b2b_spacing got irregular exp 16 cycles"); end
      end
      tests_run++; if (ready_low) begin fails++; $display("FAIL b2b_ready got low exp always high"); end
      tests_run++; if (vec_count !== 16'd10) begin fails++; $display("FAIL b2b_vec_count got %0d exp 10", vec_count); end
   endtask

   task automatic test_backpressure();
      int sent;
      do_clear();
      mac_ready = 1'b0;
      stream(0, 48, 10, 0, 0, 40, sent);
      tests_run++; if (sent != 32) begin fails++; $display("FAIL bp_accepted got %0d exp 32", sent); end
      tests_run++; if (act_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full got %0b exp 0", act_ready); end
      tests_run++; if (mac_data !== vec_t'(make_vec(10))) begin fails++; $display("FAIL bp_hold_data got %h exp %h", mac_data, make_vec(10)); end
      tests_run++; if (unstable) begin fails++; $display("FAIL bp_stable got changed exp stable"); end
      act_valid = 1'b1; act_data = make_beat(12, 0); mac_ready = 1'b1;
      #2;
      tests_run++; if (act_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_rise got %0b exp 1", act_ready); end
      stream(32, 48, 10, 0, 3, 200, sent);
      tests_run++; if (got_q.size() != 3) begin fails++; $display("FAIL bp_count got %0d exp 3", got_q.size()); end
      else begin
         for (int v = 0; v < 3; v++) exp_q.push_back(make_vec(10 + v));
         for (int v = 0; v < 3; v++) begin
            tests_run++; if (got_q[v] !== exp_q.pop_front()) begin fails++; $display("FAIL bp_data v%0d got %h exp %h", v, got_q[v], make_vec(10 + v)); end
         end
      end
   endtask

   task automatic test_bubbles();
      int sent;
      mac_ready = 1'b1;
      stream(0, 16, 20, 1, 1, 300, sent);
      tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL bub_count got %0d exp 1", got_q.size()); end
      else begin
         exp_q.push_back(make_vec(20));
         tests_run++; if (got_q[0] !== exp_q.pop_front()) begin fails++; $display("FAIL bub_data got %h exp %h", got_q[0], make_vec(20)); end
      end
      tests_run++; if (early) begin fails++; $display("FAIL bub_early got early valid exp none"); end
   endtask

   task automatic test_reset_full();
      int sent;
      mac_ready = 1'b0;
      stream(0, 48, 80, 0, 0, 40, sent);
      tests_run++; if (act_ready !== 1'b0) begin fails++; $display("FAIL rf_full_ready got %0b exp 0", act_ready); end
      tests_run++; if (vec_count === '0) begin fails++; $display("FAIL rf_precount got 0 exp nonzero"); end
      nrst = 1'b0;
      #1;
      tests_run++; if (act_ready !== 1'b0) begin fails++; $display("FAIL rf_ready_in_reset got %0b exp 0", act_ready); end
      @(posedge clk); #1;
      tests_run++; if (mac_valid !== 1'b0) begin fails++; $display("FAIL rf_mac_valid got %0b exp 0", mac_valid); end
      tests_run++; if (vec_count !== '0) begin fails++; $display("FAIL rf_vec_count got %0d exp 0", vec_count); end
      tests_run++; if (mac_data !== '0) begin fails++; $display("FAIL rf_mac_data got %h exp 0", mac_data); end
      nrst = 1'b1;
      #1;
      tests_run++; if (act_ready !== 1'b1) begin fails++; $display("FAIL rf_ready_after got %0b exp 1", act_ready); end
      mac_ready = 1'b1;
      stream(0, 16, 90, 0, 1, 100, sent);
      tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL rf_count got %0d exp 1", got_q.size()); end
      else begin
         exp_q.push_back(make_vec(90));
         tests_run++; if (got_q[0] !== exp_q.pop_front()) begin fails++; $display("FAIL rf_data got %h exp %h", got_q[0], make_vec(90)); end
         tests_run++; if (got_t[0] != 17) begin fails++; $display("FAIL rf_latency got %0d exp 17", got_t[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clear_mid_fill();
      test_back_to_back();
      test_backpressure();
      test_bubbles();
      test_reset_full();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/qracc_act_loader.md
# qracc_act_loader

Activation loader sitting directly upstream of `seq_acc`. It accepts activation elements over a narrow valid/ready stream and assembles them into one full `inputElements`-wide vector. It then presents that vector to the accelerator's `mac_data_i` / `mac_valid_i` / `ready_o` handshake. Two vector slots let the next vector fill while the current one waits for `seq_acc`, so the narrow stream runs at one beat per cycle under no backpressure.

## Interface
- `inputBits`, default 5: bits per activation element (ternary trits + 1); matches `seq_acc` `inputBits`.
- `inputElements`, default 128: elements per MAC vector (SRAM rows).
- `beatElements`, default 8: elements per input beat. `inputElements % beatElements == 0` is required; elaboration fails otherwise.
- `countBits`, default 16: width of the delivered-vector counter.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `nrst` in 1: reset. Synchronous, active-low.
- `clear_i` in 1: synchronous abort. Discards the partial fill and both slots.
- `act_data_i` in `[beatElements-1:0][inputBits-1:0]`: one beat of activation elements.
- `act_valid_i` in 1: beat valid.
- `act_ready_o` out 1: loader can take a beat this cycle.
- `mac_data_o` out `[inputElements-1:0][inputBits-1:0]`: assembled vector; drives `seq_acc` `mac_data_i`.
- `mac_valid_o` out 1: `mac_data_o` holds a complete vector; drives `mac_valid_i`.
- `mac_ready_i` in 1: from `seq_acc` `ready_o`.
- `vec_count_o` out `countBits`: number of vectors handed to `seq_acc` since reset or clear. Wraps modulo `2^countBits`.

## Operation
- `BEATS = inputElements / beatElements`.
- Beat index counter `beat_q` has width `$clog2(BEATS)`, or 1 bit if `BEATS == 1`.
- Handshakes:
  - A beat transfers when `act_valid_i && act_ready_o`.
  - A vector transfers when `mac_valid_o && mac_ready_i`.
- Element mapping: element j of beat k is written to fill-slot element `k*beatElements + j`. Data passes through unmodified and is not sign-processed.
- Fill slot state:
  - The fill slot plus `fill_full_q` form the fill half.
  - On the beat with `beat_q == BEATS-1`, `fill_full_q` sets and `beat_q` wraps to 0.
- Output slot:
  - The output register plus `out_valid_q` (which is `mac_valid_o`) form the output half.
  - Move condition: `move = fill_full_q && (!out_valid_q || mac_ready_i)`.
  - On `move`, the output register loads the fill slot, `out_valid_q` sets, and `fill_full_q` clears.
  - If `out_valid_q && mac_ready_i && !move`, then `out_valid_q` clears.
- `act_ready_o = nrst && (!fill_full_q || move)`.
  - This is a combinational path from `mac_ready_i`.
  - On a `move` cycle, an accepted beat writes beat 0 of the next vector into the fill slot at the same edge the old contents move out.
- `vec_count_o` increments by 1 on every vector transfer.
- `mac_data_o` is stable while `mac_valid_o && !mac_ready_i`. It is not required to be stable when `mac_valid_o` is low.
- `act_data_i` is ignored when the beat does not transfer.

## Timing
- Reset (`nrst` low at a rising edge):
  - `mac_valid_o = 0`, `mac_data_o = 0`, `vec_count_o = 0`, `beat_q = 0`.
  - `fill_full_q = 0`, fill slot = 0.
  - `act_ready_o` is 0 combinationally while `nrst` is low.
- Reset mid-operation discards everything. No vector is issued from pre-reset beats.
- `clear_i` at an edge:
  - Same state effect as reset, except `act_ready_o` stays high.
  - A beat or vector handshake in the clear cycle is discarded and does not count.
  - When `nrst` and `clear_i` are both active, reset wins; the effects are identical.
- Latency:
  - Last beat accepted at edge N sets `fill_full_q` at N.
  - With the output slot free, `move` happens at edge N+1, so `mac_valid_o` is high from N+1.
- Throughput: with `mac_ready_i` held at 1 and `act_valid_i` held at 1, one beat per cycle is accepted and one vector every `BEATS` cycles is delivered, with no bubbles.
- Full condition:
  - Both slots full and `mac_ready_i` low gives `act_ready_o = 0`. The held beat is not consumed.
  - `act_ready_o` rises in the same cycle `mac_ready_i` rises.
- `act_valid_i` low: no state change in the fill half.

## Test plan
- Single vector, defaults. Stimulus: 16 beats, element value `(index mod 8) - 4`, `mac_ready_i = 1`. Required response:
  - `mac_valid_o` rises 1 cycle after the last beat edge.
  - `mac_data_o[i] = (i mod 8) - 4` for all 128 elements.
  - `vec_count_o = 1` after the transfer.
- Back-to-back. Stimulus: 10 vectors streamed with `act_valid_i` held at 1 and `mac_ready_i` held at 1. Required response:
  - `act_ready_o` never low after reset.
  - Vector transfers exactly 16 cycles apart.
  - `vec_count_o = 10`.
- Backpressure. Stimulus: `mac_ready_i = 0` while 3 vectors are offered. Required response:
  - After 32 beats, `act_ready_o = 0` and `mac_data_o` stays equal to vector 0.
  - Raising `mac_ready_i` delivers vectors 0, 1, 2 in order, intact.
- Input bubbles. Stimulus: `act_valid_i` toggling 1/0 randomly across one vector. Required response: the vector is assembled correctly and `mac_valid_o` never pulses early.
- Clear mid-fill. Stimulus: assert `clear_i` after 7 beats, then send 16 fresh beats. Required response:
  - Only the fresh vector appears at `mac_data_o`.
  - No stale element appears in it.
  - `vec_count_o` equals 0 before that vector transfers.
- Reset while full. Stimulus: `nrst` low with both slots full and `mac_ready_i = 0`. Required response:
  - On the next edge, `mac_valid_o = 0` and `vec_count_o = 0`.
  - `act_ready_o = 0` while `nrst` is low.
  - `act_ready_o = 1` on the first cycle `nrst` is high.
